// File: rtl/rsa_modexp_core.sv
// Modular exponentiation C = M^E mod P: bit-serial Montgomery multiply driven by a left-to-right square-and-multiply FSM.
// Optional operand checking is enabled by defining RSA_PARAM_CHECK_EN.
module rsa_modexp_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic             eoc,
    output logic [WIDTH-1:0] C,
    output logic             err
);
    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE_M  = 3'd1;
    localparam logic [2:0] S_PRE_X  = 3'd2;
    localparam logic [2:0] S_SQUARE = 3'd3;
    localparam logic [2:0] S_MULT   = 3'd4;
    localparam logic [2:0] S_POST   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_p, r_e, r_m, r_const, r_mbar, r_x, r_c;
    logic [TW-1:0]    r_t;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_k;
    logic             r_eoc;

    logic [WIDTH-1:0] w_mm_a, w_mm_b, w_a_sh, w_mm_res;
    logic [TW-1:0]    w_t1, w_t2, w_t_next, w_t_red;
    logic             w_abit, w_mm_last;
    logic [2:0]       w_after;

    // Operand routing for the multiplier, selected by phase
    always_comb begin
        w_mm_a = '0;
        w_mm_b = '0;
        case (r_state)
            S_PRE_M:  begin w_mm_a = r_m;                 w_mm_b = r_const; end
            S_PRE_X:  begin w_mm_a = WIDTH'(1);           w_mm_b = r_const; end
            S_SQUARE: begin w_mm_a = r_x;                 w_mm_b = r_x;     end
            S_MULT:   begin w_mm_a = r_x;                 w_mm_b = r_mbar;  end
            S_POST:   begin w_mm_a = r_x;                 w_mm_b = WIDTH'(1); end
            default:  begin w_mm_a = '0;                  w_mm_b = '0;      end
        endcase
    end

    assign w_a_sh    = w_mm_a >> r_cnt;
    assign w_abit    = w_a_sh[0];
    assign w_t1      = r_t + (w_abit ? {2'b00, w_mm_b} : '0);
    assign w_t2      = w_t1[0] ? (w_t1 + {2'b00, r_p}) : w_t1;
    assign w_t_next  = w_t2 >> 1;
    assign w_t_red   = (r_t >= {2'b00, r_p}) ? (r_t - {2'b00, r_p}) : r_t;
    assign w_mm_res  = w_t_red[WIDTH-1:0];
    assign w_mm_last = (r_cnt == CW'(WIDTH));
    assign w_after   = (r_k == '0) ? S_POST : S_SQUARE;

`ifdef RSA_PARAM_CHECK_EN
    logic r_err;
    logic w_bad;
    assign w_bad = !r_p[0] || (r_p < WIDTH'(3)) || (r_const >= r_p);
    assign err   = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_e     <= '0;
            r_m     <= '0;
            r_const <= '0;
            r_mbar  <= '0;
            r_x     <= '0;
            r_c     <= '0;
            r_t     <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_eoc   <= 1'b0;
`ifdef RSA_PARAM_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_p     <= P;
                        r_e     <= E;
                        r_m     <= M;
                        r_const <= Const;
                        r_t     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_PRE_M;
                    end
                end
                S_DONE: begin
                    // eoc rises one edge after entering DONE and drops on the edge that leaves it
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_eoc   <= 1'b0;
`ifdef RSA_PARAM_CHECK_EN
                        r_err   <= 1'b0;
`endif
                    end else begin
                        r_eoc <= 1'b1;
                    end
                end
                default: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_t     <= '0;
                        r_cnt   <= '0;
                    end else
`ifdef RSA_PARAM_CHECK_EN
                    if (r_state == S_PRE_M && r_cnt == '0 && w_bad) begin
                        r_state <= S_DONE;
                        r_c     <= '0;
                        r_eoc   <= 1'b1;
                        r_err   <= 1'b1;
                    end else
`endif
                    if (!w_mm_last) begin
                        r_t   <= w_t_next;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_t   <= '0;
                        r_cnt <= '0;
                        case (r_state)
                            S_PRE_M: begin
                                r_mbar  <= w_mm_res;
                                r_state <= S_PRE_X;
                            end
                            S_PRE_X: begin
                                r_x     <= w_mm_res;
                                r_k     <= KW'(WIDTH - 1);
                                r_state <= S_SQUARE;
                            end
                            S_SQUARE: begin
                                r_x <= w_mm_res;
                                if (r_e[r_k]) begin
                                    r_state <= S_MULT;
                                end else begin
                                    r_state <= w_after;
                                    if (r_k != '0) r_k <= r_k - 1'b1;
                                end
                            end
                            S_MULT: begin
                                r_x     <= w_mm_res;
                                r_state <= w_after;
                                if (r_k != '0) r_k <= r_k - 1'b1;
                            end
                            S_POST: begin
                                r_c     <= w_mm_res;
                                r_state <= S_DONE;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign eoc = r_eoc;
    assign C   = r_c;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed-vector bench for rsa_modexp_core (WIDTH=8); checks result, latency, abort and reset behaviour.
module tb_rsa_modexp_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] P, E, M, Const;
    logic       eoc;
    logic [7:0] C;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    rsa_modexp_core #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .P     (P),
        .E     (E),
        .M     (M),
        .Const (Const),
        .eoc   (eoc),
        .C     (C),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Capture a vector, scramble inputs afterwards, count edges until eoc
    task automatic run_vec(input string tag, input logic [7:0] p, input logic [7:0] e,
                           input logic [7:0] m, input logic [7:0] cst, input logic [7:0] exp_c,
                           input bit chk_c, input int exp_lat, input logic exp_err);
        int n;
        @(negedge clk);
        P = p; E = e; M = m; Const = cst; en = 1'b1;
        @(posedge clk); #1;
        P = 8'hA6; E = 8'h5A; M = 8'h33; Const = 8'hF0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!eoc && n < 400);
        check({tag, "_lat"}, n, exp_lat);
        if (chk_c) check({tag, "_c"}, C, exp_c);
        check({tag, "_err"}, err, exp_err);
        $display("run %s: P=%0d E=%0d M=%0d Const=%0d -> C=%0d err=%0d latency=%0d",
                 tag, p, e, m, cst, C, err, n);
    endtask

    task automatic end_run(input string tag, input logic [7:0] exp_c);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check({tag, "_eoc_drop"}, eoc, 1'b0);
        check({tag, "_c_kept"}, C, exp_c);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; en = 1'b0; P = '0; E = '0; M = '0; Const = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_eoc", eoc, 1'b0);
        check("rst_c", C, 8'd0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RSA_PARAM_CHECK_EN
        run_vec("chk_p_even", 8'd12, 8'd3, 8'd4, 8'd3, 8'd0, 1'b1, 1, 1'b1);
        end_run("chk_p_even", 8'd0);
        check("chk_p_even_err_clr", err, 1'b0);
        run_vec("chk_const", 8'd13, 8'd3, 8'd4, 8'd13, 8'd0, 1'b1, 1, 1'b1);
        end_run("chk_const", 8'd0);
`endif

        run_vec("case1", 8'd13, 8'd3, 8'd4, 8'd3, 8'd12, 1'b1, 118, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("case1_eoc_hold", eoc, 1'b1);
        check("case1_c_hold", C, 8'd12);
        end_run("case1", 8'd12);

        run_vec("e_zero", 8'd13, 8'd0, 8'd7, 8'd3, 8'd1, 1'b1, 100, 1'b0);
        end_run("e_zero", 8'd1);
        run_vec("m_gt_p", 8'd13, 8'd2, 8'd20, 8'd3, 8'd10, 1'b1, 109, 1'b0);
        end_run("m_gt_p", 8'd10);
        run_vec("m_zero", 8'd13, 8'd5, 8'd0, 8'd3, 8'd0, 1'b1, 9 * 13 + 1, 1'b0);
        end_run("m_zero", 8'd0);
        run_vec("p251", 8'd251, 8'd255, 8'd2, 8'd25, 8'd32, 1'b1, 172, 1'b0);
        end_run("p251", 8'd32);

`ifndef RSA_PARAM_CHECK_EN
        run_vec("ooc_p_even", 8'd12, 8'd3, 8'd4, 8'd3, 8'd0, 1'b0, 118, 1'b0);
        end_run("ooc_p_even", C);
        run_vec("p251_again", 8'd251, 8'd255, 8'd2, 8'd25, 8'd32, 1'b1, 172, 1'b0);
        end_run("p251_again", 8'd32);
`endif

        // Abort: en sampled low at edge 30 after capture
        @(negedge clk);
        P = 8'd13; E = 8'd3; M = 8'd4; Const = 8'd3; en = 1'b1;
        @(posedge clk);
        repeat (29) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (eoc) seen = 1'b1;
        end
        check("abort_no_eoc", seen, 1'b0);
        check("abort_c_kept", C, 8'd32);
        $display("run abort: en dropped at edge 30, eoc_seen=%0d C=%0d", seen, C);
        run_vec("rerun", 8'd13, 8'd3, 8'd4, 8'd3, 8'd12, 1'b1, 118, 1'b0);
        end_run("rerun", 8'd12);

        // Reset at edge 50 of a run
        @(negedge clk);
        P = 8'd13; E = 8'd3; M = 8'd4; Const = 8'd3; en = 1'b1;
        @(posedge clk);
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_c", C, 8'd0);
        check("midrst_eoc", eoc, 1'b0);
        check("midrst_err", err, 1'b0);
        $display("run midrst: rst at edge 50, C=%0d eoc=%0d err=%0d", C, eoc, err);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        run_vec("post_rst", 8'd13, 8'd2, 8'd20, 8'd3, 8'd10, 1'b1, 109, 1'b0);
        end_run("post_rst", 8'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
- Modular exponentiation engine, C = M^E mod P, using bit-serial Montgomery multiplication with left-to-right square-and-multiply.
- Sits directly downstream of the RSA enable controller:
  - consumes its en/reset level;
  - returns eoc, which the controller turns into the IRQ.
- Operands come from the SPI register file: P, E, M, Const = R^2 mod P, with R = 2^WIDTH.
- Result C is written back to the register file.

Parameters:
WIDTH, 8, operand/result width in bits; R = 2^WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
en  input  1  level run enable from controller; low aborts
P  input  WIDTH  modulus, must be odd and >= 3
E  input  WIDTH  exponent
M  input  WIDTH  message, any value 0..2^WIDTH-1
Const  input  WIDTH  R^2 mod P, must be < P
eoc  output  1  end of computation, level
C  output  WIDTH  result
err  output  1  parameter error (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; eoc=0, C=0, err=0; all internal registers 0.
  - Reset takes priority over everything, including mid-operation.
- Operand capture: P, E, M, Const are registered on the edge where en=1 is sampled in IDLE. Later input changes are ignored until the next run.
- Montgomery multiply MM(a,b) = a*b*R^-1 mod P. Each MM takes WIDTH+1 cycles:
  - Iteration cycles i = 0..WIDTH-1: t = t + a[i]*b; if t odd, t = t + P; t = t >> 1. The accumulator t is WIDTH+2 bits wide.
  - Final cycle: if t >= P, t = t - P; result is WIDTH bits.
  - Contract: b < P, a < 2^WIDTH; the result is then < P.
- States:
  - IDLE: en=1 -> capture operands, go to PRE_M.
  - PRE_M: Mbar = MM(M, Const) -> PRE_X.
  - PRE_X: X = MM(1, Const), i.e. R mod P; bit index k = WIDTH-1 -> SQUARE.
  - SQUARE: X = MM(X, X). Then if E[k]=1 -> MULT, else -> NEXT.
  - MULT: X = MM(X, Mbar) -> NEXT.
  - NEXT (0 cycles, folded into the transition): if k=0 -> POST, else k = k-1 -> SQUARE.
  - POST: C register loaded with MM(X, 1) -> DONE.
  - DONE: eoc=1; C held. en=0 -> IDLE with eoc=0 on the next edge; C is retained.
- Latency: eoc first reads 1 exactly L = (WIDTH+1)*(3+WIDTH+popcount(E)) + 1 edges after the capturing edge.
- Abort: en=0 in any busy state -> IDLE on the next edge.
  - eoc stays 0; C keeps its previous value.
  - A fresh run starts only when en=1 is sampled again in IDLE.
- en held high in DONE: stays in DONE; there is no automatic restart.
- Boundary cases:
  - E=0 -> C = 1 (P >= 3).
  - M >= P is valid; it is reduced implicitly.
  - M=0 -> C=0 when E != 0.
- Out-of-contract inputs (P even, P < 3, Const >= P) with the feature off: C is undefined but the FSM still terminates with latency L.

Optional Feature:
- Macro: RSA_PARAM_CHECK_EN.
- Defined:
  - At capture, if P[0]=0, P<3, or Const>=P -> jump straight to DONE on the next edge with C=0, err=1, eoc=1.
  - err clears when leaving DONE or on rst.
  - Valid operands behave as without the macro; err=0.
- Undefined: no checking logic; err is tied 0; invalid operands follow the out-of-contract rule.

Test Plan:
- WIDTH=8, P=13, E=3, M=4, Const=3, en=1 -> C=0x0C (12), eoc rises exactly 118 edges after capture and holds while en=1; en=0 -> eoc=0 next edge, C stays 12.
- P=13, E=0, M=7, Const=3 -> C=1, latency 100 edges.
- P=13, E=2, M=20 (M>P), Const=3 -> C=10, latency 109 edges.
- P=251, E=255, M=2, Const=25 -> C=32 (0x20), latency 172 edges.
- Interruptions:
  - Start the case-1 vector, drop en at edge 30 -> eoc never asserts, FSM returns to IDLE, and a re-run gives C=12 at 118 edges.
  - Assert rst at edge 50 of a run -> C=0, eoc=0, err=0 the following cycle.
- With RSA_PARAM_CHECK_EN:
  - P=12 -> eoc=1, err=1, C=0 one edge after capture.
  - P=13, Const=13 -> same error response.
  - Case-1 vector -> err=0, C=12.
